mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Consumer end of the EX/MEM pipeline register: the MEM stage of the 5-stage 64-bit RISC-V pipeline.
- Performs doubleword loads and stores against a multi-cycle data memory over a req/ack handshake.
- Stalls upstream stages while an access is outstanding and resolves branches (PCSrc).
- Contains the MEM/WB pipeline register that feeds writeback.

Parameters:
TIMEOUT_CYCLES, 16, max cycles dmem_req stays high without dmem_ack before the access is aborted (>=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
EXMEM_Result  in  64  ALU result; memory address for loads/stores
EXMEM_ReadData2  in  64  store data
EXMEM_out  in  64  branch target address
EXMEM_inst2  in  5  destination register rd
EXMEM_ZERO, EXMEM_Branch, EXMEM_MemRead, EXMEM_MemWrite, EXMEM_MemtoReg, EXMEM_RegWrite  in  1 each  control from EX/MEM
dmem_ack  in  1  memory completion strobe
dmem_rdata  in  64  load data, valid when dmem_ack=1
dmem_req  out  1  access request
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  64  equals EXMEM_Result
dmem_wdata  out  64  equals EXMEM_ReadData2
stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle
PCSrc  out  1  take branch
branch_target  out  64  equals EXMEM_out
mem_err  out  1  sticky error flag
MEMWB_ReadData, MEMWB_Result  out  64 each  to writeback
MEMWB_rd  out  5  to writeback
MEMWB_RegWrite, MEMWB_MemtoReg  out  1 each  to writeback

Behaviour:
- Reset (reset=0, async): state=IDLE, wait counter=0, mem_err=0, all MEMWB_* outputs=0. dmem_req and stall drop immediately, including when reset hits mid-access. The aborted access is not retried after reset.
- acc = MemRead XOR MemWrite. ill = MemRead AND MemWrite. mis = acc AND (EXMEM_Result[2:0] != 0).
- State IDLE:
  - acc and not mis: stall=1, go to ACCESS, counter=0, MEM/WB loads a bubble.
  - ill or mis: no request, stall=0, mem_err<=1, MEM/WB loads a bubble (instruction retires with no effect).
  - Otherwise (ALU op, branch, nop): stall=0, MEM/WB loads MEMWB_Result=EXMEM_Result, rd, RegWrite, MemtoReg. MEMWB_ReadData keeps its previous value.
- State ACCESS:
  - dmem_req=1, dmem_we=EXMEM_MemWrite. Address and data are driven combinationally from the held EX/MEM inputs.
  - dmem_ack=1: stall=0, go to IDLE, MEM/WB loads the full instruction (ReadData=dmem_rdata for loads).
  - No ack and counter=TIMEOUT_CYCLES-1: stall=0, mem_err<=1, go to IDLE, MEM/WB loads a bubble.
  - Otherwise: stall=1, counter increments, MEM/WB loads a bubble.
  - dmem_ack and timeout in the same cycle: ack wins.
  - dmem_ack while in IDLE: ignored.
- Bubble definition: MEMWB_RegWrite=0 and MEMWB_MemtoReg=0. Data and rd fields are don't-care but must hold their previous values.
- Latency: a non-memory instruction reaches MEM/WB on the next edge. A memory op with ack on request cycle k (k>=1) holds stall for k cycles and reaches MEM/WB on the edge ending cycle k.
- stall, PCSrc, dmem_* are combinational from state and inputs, with no path from stall back to EXMEM_* inside this block.
- PCSrc = EXMEM_Branch AND EXMEM_ZERO, independent of state.
- mem_err clears only on reset.

Decomposition:
- Shared pipeline package: state enum {IDLE, ACCESS}, DWORD_ALIGN_MASK=3'b111, BUBBLE control constants.
- One natural sub-module, mem_wb_reg: the MEM/WB register with load/bubble select. Async active-low reset, same clk/reset names.

Test Plan:
1. ALU op, Result=0x10, rd=5, RegWrite=1 -> stall never high; after one edge MEMWB_Result=0x10, MEMWB_rd=5, MEMWB_RegWrite=1.
2. Load addr 0x100, ack 3 cycles after dmem_req rises with rdata 0xDEADBEEF -> stall high 3 cycles, dmem_req high 3 cycles, dmem_we=0; then MEMWB_ReadData=0xDEADBEEF, MemtoReg=1, preceded by bubbles.
3. Store addr 0x8, wdata 0x55, ack on first request cycle -> dmem_we=1, dmem_wdata=0x55, stall high 1 cycle, MEMWB_RegWrite=0.
4. TIMEOUT_CYCLES=4, load with no ack -> dmem_req high exactly 4 cycles, then mem_err=1, bubble written, stall low, state IDLE.
5. Misaligned load at 0x104, then MemRead=MemWrite=1 -> dmem_req never rises, mem_err=1, MEMWB_RegWrite=0, no stall.
6. Branch=1, ZERO=1, out=0x40 -> PCSrc=1, branch_target=0x40 the same cycle. Separately, reset=0 during ACCESS -> dmem_req, stall, mem_err, MEMWB_* all 0 immediately, before any clock edge.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared MEM-stage definitions: access FSM states, alignment mask,
// MEM/WB payload and bubble control values.
package mem_access_stage_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned REG_W = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [2:0] DWORD_ALIGN_MASK = 3'b111;

    localparam logic BUBBLE_REGWRITE = 1'b0;
    localparam logic BUBBLE_MEMTOREG = 1'b0;

    typedef struct packed {
        logic [XLEN-1:0]  read_data;
        logic [XLEN-1:0]  result;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_to_reg;
    } memwb_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr[2:0] & DWORD_ALIGN_MASK) != 3'b000;
    endfunction

endpackage

// File: rtl/mem_access_stage_wb_reg.sv
// MEM/WB pipeline register; a bubble clears only the writeback controls
// and leaves the data fields holding their previous contents.
module mem_wb_reg
    import mem_access_stage_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   load_rdata,
    input  memwb_t d,
    output memwb_t q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q.result     <= d.result;
            q.rd         <= d.rd;
            q.reg_write  <= d.reg_write;
            q.mem_to_reg <= d.mem_to_reg;
            if (load_rdata) begin
                q.read_data <= d.read_data;
            end
        end else begin
            q.reg_write  <= BUBBLE_REGWRITE;
            q.mem_to_reg <= BUBBLE_MEMTOREG;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: doubleword load/store over a req/ack data memory with timeout,
// upstream stall, branch resolution and the MEM/WB register.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  EXMEM_Result,
    input  logic [XLEN-1:0]  EXMEM_ReadData2,
    input  logic [XLEN-1:0]  EXMEM_out,
    input  logic [REG_W-1:0] EXMEM_inst2,
    input  logic             EXMEM_ZERO,
    input  logic             EXMEM_Branch,
    input  logic             EXMEM_MemRead,
    input  logic             EXMEM_MemWrite,
    input  logic             EXMEM_MemtoReg,
    input  logic             EXMEM_RegWrite,
    input  logic             dmem_ack,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    output logic             stall,
    output logic             PCSrc,
    output logic [XLEN-1:0]  branch_target,
    output logic             mem_err,
    output logic [XLEN-1:0]  MEMWB_ReadData,
    output logic [XLEN-1:0]  MEMWB_Result,
    output logic [REG_W-1:0] MEMWB_rd,
    output logic             MEMWB_RegWrite,
    output logic             MEMWB_MemtoReg
);

    localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             acc, ill, mis;
    logic             stall_c, req_c;
    logic             wb_load, wb_load_rdata;
    memwb_t           wb_d, wb_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Access decode, next state and MEM/WB load select.
    always_comb begin
        acc           = EXMEM_MemRead ^ EXMEM_MemWrite;
        ill           = EXMEM_MemRead & EXMEM_MemWrite;
        mis           = acc & is_misaligned(EXMEM_Result);
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        stall_c       = 1'b0;
        req_c         = 1'b0;
        wb_load       = 1'b0;
        wb_load_rdata = 1'b0;
        if (state_q == IDLE) begin
            if (acc && !mis) begin
                stall_c = 1'b1;
                state_d = ACCESS;
                cnt_d   = '0;
            end else if (ill || mis) begin
                err_d = 1'b1;
            end else begin
                wb_load = 1'b1;
            end
        end else begin
            req_c = 1'b1;
            // A same-cycle ack beats the timeout.
            if (dmem_ack) begin
                state_d       = IDLE;
                wb_load       = 1'b1;
                wb_load_rdata = EXMEM_MemRead;
            end else if (cnt_q == CNT_LAST) begin
                state_d = IDLE;
                err_d   = 1'b1;
            end else begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    // Gated by reset so a mid-access reset drops request and stall at once.
    assign stall         = reset & stall_c;
    assign dmem_req      = reset & req_c;
    assign dmem_we       = dmem_req & EXMEM_MemWrite;
    assign dmem_addr     = EXMEM_Result;
    assign dmem_wdata    = EXMEM_ReadData2;
    assign PCSrc         = EXMEM_Branch & EXMEM_ZERO;
    assign branch_target = EXMEM_out;
    assign mem_err       = err_q;

    assign wb_d.read_data  = dmem_rdata;
    assign wb_d.result     = EXMEM_Result;
    assign wb_d.rd         = EXMEM_inst2;
    assign wb_d.reg_write  = EXMEM_RegWrite;
    assign wb_d.mem_to_reg = EXMEM_MemtoReg;

    mem_wb_reg u_mem_wb_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (wb_load),
        .load_rdata (wb_load_rdata),
        .d          (wb_d),
        .q          (wb_q)
    );

    assign MEMWB_ReadData = wb_q.read_data;
    assign MEMWB_Result   = wb_q.result;
    assign MEMWB_rd       = wb_q.rd;
    assign MEMWB_RegWrite = wb_q.reg_write;
    assign MEMWB_MemtoReg = wb_q.mem_to_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a driver plays the pipeline and the
// data memory, a monitor checks every MEM/WB write against a reference model.
module tb_mem_access_stage;

    localparam int unsigned T = 4;

    logic        clk;
    logic        reset;
    logic [63:0] EXMEM_Result, EXMEM_ReadData2, EXMEM_out;
    logic [4:0]  EXMEM_inst2;
    logic        EXMEM_ZERO, EXMEM_Branch, EXMEM_MemRead, EXMEM_MemWrite;
    logic        EXMEM_MemtoReg, EXMEM_RegWrite;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        dmem_req, dmem_we, stall, PCSrc, mem_err;
    logic [63:0] dmem_addr, dmem_wdata, branch_target;
    logic [63:0] MEMWB_ReadData, MEMWB_Result;
    logic [4:0]  MEMWB_rd;
    logic        MEMWB_RegWrite, MEMWB_MemtoReg;

    mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .EXMEM_Result(EXMEM_Result), .EXMEM_ReadData2(EXMEM_ReadData2),
        .EXMEM_out(EXMEM_out), .EXMEM_inst2(EXMEM_inst2),
        .EXMEM_ZERO(EXMEM_ZERO), .EXMEM_Branch(EXMEM_Branch),
        .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite),
        .EXMEM_MemtoReg(EXMEM_MemtoReg), .EXMEM_RegWrite(EXMEM_RegWrite),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .stall(stall), .PCSrc(PCSrc),
        .branch_target(branch_target), .mem_err(mem_err),
        .MEMWB_ReadData(MEMWB_ReadData), .MEMWB_Result(MEMWB_Result),
        .MEMWB_rd(MEMWB_rd), .MEMWB_RegWrite(MEMWB_RegWrite),
        .MEMWB_MemtoReg(MEMWB_MemtoReg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] result, wdata, target, rdata;
        logic [4:0]  rd;
        logic        mr, mw, rw, m2r, br, zero, spur;
        int          ack_k;   // request cycle on which memory acks; 0 = never
    } instr_t;

    typedef struct {
        logic [63:0] result, rdata;
        logic [4:0]  rd;
        logic        rw, m2r;
    } wb_t;

    wb_t    exp_q[$];
    wb_t    model_wb;
    logic   model_err;
    instr_t cur;
    int     n_cmp  = 0;
    int     n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(input logic mr, input logic mw, input logic [63:0] addr,
                                  input logic [63:0] wdata, input logic [4:0] rd,
                                  input logic rw, input logic m2r, input int ack_k,
                                  input logic [63:0] rdata);
        instr_t i;
        i.result = addr;  i.wdata = wdata; i.target = 64'h0; i.rdata = rdata;
        i.rd = rd; i.mr = mr; i.mw = mw; i.rw = rw; i.m2r = m2r;
        i.br = 1'b0; i.zero = 1'b0; i.spur = 1'b0; i.ack_k = ack_k;
        return i;
    endfunction

    // Reference model: outcome of one instruction, stated in terms of its effect.
    task automatic model(input instr_t in, output int exp_req, output int exp_stall);
        bit is_mem, bad;
        is_mem    = (in.mr != in.mw);
        bad       = (in.mr && in.mw) || (is_mem && (in.result % 8 != 0));
        exp_req   = 0;
        exp_stall = 0;
        if (bad) begin
            model_err    = 1'b1;
            model_wb.rw  = 1'b0;
            model_wb.m2r = 1'b0;
        end else if (is_mem && (in.ack_k < 1 || in.ack_k > int'(T))) begin
            exp_req      = T;
            exp_stall    = T;
            model_err    = 1'b1;
            model_wb.rw  = 1'b0;
            model_wb.m2r = 1'b0;
        end else begin
            if (is_mem) begin
                exp_req   = in.ack_k;
                exp_stall = in.ack_k;
                if (in.mr) model_wb.rdata = in.rdata;
            end
            model_wb.result = in.result;
            model_wb.rd     = in.rd;
            model_wb.rw     = in.rw;
            model_wb.m2r    = in.m2r;
        end
        exp_q.push_back(model_wb);
    endtask

    task automatic drive(input instr_t in);
        EXMEM_Result    = in.result;
        EXMEM_ReadData2 = in.wdata;
        EXMEM_out       = in.target;
        EXMEM_inst2     = in.rd;
        EXMEM_MemRead   = in.mr;
        EXMEM_MemWrite  = in.mw;
        EXMEM_RegWrite  = in.rw;
        EXMEM_MemtoReg  = in.m2r;
        EXMEM_Branch    = in.br;
        EXMEM_ZERO      = in.zero;
        dmem_rdata      = in.rdata;
        dmem_ack        = in.spur;
        cur             = in;
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_instr(input instr_t in);
        int  exp_req, exp_stall, req_cnt, stall_cnt;
        bit  done;
        drive(in);
        model(in, exp_req, exp_stall);
        req_cnt   = 0;
        stall_cnt = 0;
        done      = 1'b0;
        for (int i = 0; i < int'(T) + 4 && !done; i++) begin
            if (i > 0) dmem_ack = 1'b0;
            #1;
            if (dmem_req) begin
                req_cnt++;
                if (req_cnt == in.ack_k) dmem_ack = 1'b1;
            end
            #1;
            if (stall) stall_cnt++;
            else       done = 1'b1;
            @(negedge clk);
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL stall_bound: stall still high after %0d cycles", T + 4);
        end
        dmem_ack = 1'b0;
        check("req_cycles", 64'(req_cnt), 64'(exp_req));
        check("stall_cycles", 64'(stall_cnt), 64'(exp_stall));
        check("mem_err", 64'(mem_err), 64'(model_err));
    endtask

    // Monitor: combinational outputs each cycle, MEM/WB after every retiring edge.
    initial begin : monitor
        bit  will;
        wb_t e;
        forever begin
            @(negedge clk);
            #3;
            will = 1'b0;
            if (reset === 1'b1) begin
                check("PCSrc", 64'(PCSrc), 64'(EXMEM_Branch & EXMEM_ZERO));
                check("branch_target", branch_target, EXMEM_out);
                if (dmem_req) begin
                    check("dmem_addr", dmem_addr, cur.result);
                    check("dmem_we", 64'(dmem_we), 64'(cur.mw));
                    if (cur.mw) check("dmem_wdata", dmem_wdata, cur.wdata);
                end
                will = !stall;
            end
            @(posedge clk);
            #1;
            if (will) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: DUT retired with no expectation");
                end else begin
                    e = exp_q.pop_front();
                    check("MEMWB_RegWrite", 64'(MEMWB_RegWrite), 64'(e.rw));
                    check("MEMWB_MemtoReg", 64'(MEMWB_MemtoReg), 64'(e.m2r));
                    check("MEMWB_Result", MEMWB_Result, e.result);
                    check("MEMWB_rd", 64'(MEMWB_rd), 64'(e.rd));
                    check("MEMWB_ReadData", MEMWB_ReadData, e.rdata);
                end
            end
        end
    end

    initial begin : stim
        instr_t in;
        int     kind;
        drive(mk(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 0, 64'h0));
        reset     = 1'b1;
        model_wb  = '{result: 64'h0, rdata: 64'h0, rd: 5'd0, rw: 1'b0, m2r: 1'b0};
        model_err = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("rst_MEMWB_Result", MEMWB_Result, 64'h0);
        check("rst_MEMWB_RegWrite", 64'(MEMWB_RegWrite), 64'h0);
        check("rst_mem_err", 64'(mem_err), 64'h0);
        check("rst_stall", 64'(stall), 64'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Directed cases
        run_instr(mk(1'b0, 1'b0, 64'h10, 64'h0, 5'd5, 1'b1, 1'b0, 0, 64'h0));
        run_instr(mk(1'b1, 1'b0, 64'h100, 64'h0, 5'd7, 1'b1, 1'b1, 3, 64'hDEADBEEF));
        run_instr(mk(1'b0, 1'b1, 64'h8, 64'h55, 5'd0, 1'b0, 1'b0, 1, 64'h0));
        run_instr(mk(1'b1, 1'b0, 64'h200, 64'h0, 5'd9, 1'b1, 1'b1, 0, 64'h1234));
        run_instr(mk(1'b1, 1'b0, 64'h104, 64'h0, 5'd3, 1'b1, 1'b1, 1, 64'h99));
        run_instr(mk(1'b1, 1'b1, 64'h10, 64'h7, 5'd4, 1'b1, 1'b0, 1, 64'h98));
        run_instr(mk(1'b1, 1'b0, 64'h1F8, 64'h0, 5'd11, 1'b1, 1'b1, T, 64'hCAFE));
        in = mk(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 0, 64'h0);
        in.br = 1'b1; in.zero = 1'b1; in.target = 64'h40; in.spur = 1'b1;
        run_instr(in);

        // Randomised instruction stream
        for (int n = 0; n < 200; n++) begin
            kind = int'($urandom_range(0, 9));
            in = mk(1'b0, 1'b0, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                    5'($urandom()), 1'($urandom()), 1'($urandom()),
                    int'($urandom_range(0, T)), {$urandom(), $urandom()});
            if (kind <= 3) begin
                in.mr = 1'b1; in.m2r = 1'b1;
            end else if (kind <= 6) begin
                in.mw = 1'b1;
            end else if (kind == 7) begin
                in.mr = 1'b1; in.mw = 1'b1;
            end
            if (kind <= 6 && $urandom_range(0, 4) != 0) in.result[2:0] = 3'b000;
            in.br   = 1'($urandom());
            in.zero = 1'($urandom());
            in.target = {$urandom(), $urandom()};
            in.spur = 1'($urandom());
            run_instr(in);
        end

        // Reset in the middle of an outstanding access
        in = mk(1'b1, 1'b0, 64'h300, 64'h0, 5'd2, 1'b1, 1'b1, 0, 64'h0);
        drive(in);
        @(negedge clk);
        #2;
        check("pre_reset_dmem_req", 64'(dmem_req), 64'h1);
        check("pre_reset_mem_err", 64'(mem_err), 64'h1);
        reset = 1'b0;
        #1;
        check("rst_mid_dmem_req", 64'(dmem_req), 64'h0);
        check("rst_mid_stall", 64'(stall), 64'h0);
        check("rst_mid_mem_err", 64'(mem_err), 64'h0);
        check("rst_mid_MEMWB_Result", MEMWB_Result, 64'h0);
        check("rst_mid_MEMWB_ReadData", MEMWB_ReadData, 64'h0);
        check("rst_mid_MEMWB_rd", 64'(MEMWB_rd), 64'h0);
        check("rst_mid_MEMWB_RegWrite", 64'(MEMWB_RegWrite), 64'h0);
        check("rst_mid_MEMWB_MemtoReg", 64'(MEMWB_MemtoReg), 64'h0);
        drive(mk(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 0, 64'h0));
        model_wb  = '{result: 64'h0, rdata: 64'h0, rd: 5'd0, rw: 1'b0, m2r: 1'b0};
        model_err = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_instr(mk(1'b0, 1'b0, 64'h20, 64'h0, 5'd6, 1'b1, 1'b0, 0, 64'h0));
        run_instr(mk(1'b0, 1'b1, 64'h28, 64'hAA, 5'd0, 1'b0, 1'b0, 2, 64'h0));

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
